// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: shared types for the stack command sequencer.
// Optional feature macro: STACK_SEQ_FLAGS_EN (adds flag_z / flag_c outputs).
package stack_seq_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_POP  = 3'd2,
    OP_TOS  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_AND  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH_R,
    S_POP_A,
    S_TOS_A,
    S_CAP_A,
    S_POP_B,
    S_CAP_B,
    S_DONE
  } state_e;

endpackage

// File: rtl/stack_seq_alu.sv
// stack_seq_alu: combinational ALU for the stack sequencer.
// a is the old top of stack, b the entry beneath it; SUB yields b-a.
// Optional feature macro: STACK_SEQ_FLAGS_EN (adds carry/borrow output).
module stack_seq_alu
  import stack_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  op_e              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] res
`ifdef STACK_SEQ_FLAGS_EN
  ,
  output logic             carry
`endif
);

`ifdef STACK_SEQ_FLAGS_EN
  // Result plus carry (ADD) or borrow (SUB); AND/NOT clear carry
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD:  {carry, res} = {1'b0, a} + {1'b0, b};
      OP_SUB:  {carry, res} = {1'b0, b} - {1'b0, a};
      OP_AND:  res = a & b;
      OP_NOT:  res = ~a;
      default: res = '0;
    endcase
  end
`else
  // Result only, wrapping modulo 2^DATA_W
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = b - a;
      OP_AND:  res = a & b;
      OP_NOT:  res = ~a;
      default: res = '0;
    endcase
  end
`endif

endmodule

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: command-side master for a DEPTH-entry hardware stack.
// Issues single-cycle push/pop/tos strobes, captures stack read data,
// writes ALU results back, and guards over/underflow with a shadow depth.
// Optional feature macro: STACK_SEQ_FLAGS_EN (registered flag_z / flag_c).
module stack_op_sequencer
  import stack_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = 32,
  parameter int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [DATA_W-1:0]  cmd_imm,
  output logic [DATA_W-1:0]  stk_din,
  output logic               stk_push,
  output logic               stk_pop,
  output logic               stk_tos,
  input  logic [DATA_W-1:0]  stk_dout,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  output logic               op_done,
  output logic               err_underflow,
  output logic               err_overflow,
  output logic [DEPTH_W-1:0] depth
`ifdef STACK_SEQ_FLAGS_EN
  ,
  output logic               flag_z,
  output logic               flag_c
`endif
);

  localparam logic [DEPTH_W-1:0] LP_FULL = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] LP_TWO  = DEPTH_W'(2);

  state_e              r_state;
  op_e                 r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_din;
  logic [DATA_W-1:0]   r_result;
  logic                r_rv;
  logic                r_uf;
  logic                r_of;
  logic [DEPTH_W-1:0]  r_depth;
  op_e                 w_op;
  logic [DATA_W-1:0]   w_alu_a;
  logic [DATA_W-1:0]   w_alu_res;
`ifdef STACK_SEQ_FLAGS_EN
  logic                w_alu_carry;
  logic                r_carry;
  logic                r_flag_z;
  logic                r_flag_c;
`endif

  assign w_op = op_e'(cmd_op);

  // In CAP_A the fresh top is on stk_dout (NOT path); in CAP_B it is held in r_a
  assign w_alu_a = (r_state == S_CAP_A) ? stk_dout : r_a;

  stack_seq_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op   (r_op),
    .a    (w_alu_a),
    .b    (stk_dout),
    .res  (w_alu_res)
`ifdef STACK_SEQ_FLAGS_EN
    ,
    .carry(w_alu_carry)
`endif
  );

  // Command FSM, shadow depth counter and registered result/status
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_op     <= OP_NOP;
      r_a      <= '0;
      r_din    <= '0;
      r_result <= '0;
      r_rv     <= 1'b0;
      r_uf     <= 1'b0;
      r_of     <= 1'b0;
      r_depth  <= '0;
`ifdef STACK_SEQ_FLAGS_EN
      r_carry  <= 1'b0;
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
`endif
    end else begin
      r_rv <= 1'b0;
      r_uf <= 1'b0;
      r_of <= 1'b0;

      if (r_state == S_PUSH_R) begin
        r_depth <= r_depth + 1'b1;
      end else if (r_state == S_POP_A || r_state == S_POP_B) begin
        r_depth <= r_depth - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_op <= w_op;
            case (w_op)
              OP_NOP: r_state <= S_DONE;
              OP_PUSH: begin
                if (r_depth == LP_FULL) begin
                  r_of    <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_din   <= cmd_imm;
                  r_state <= S_PUSH_R;
                end
              end
              OP_POP, OP_NOT: begin
                if (r_depth == '0) begin
                  r_uf    <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_state <= S_POP_A;
                end
              end
              OP_TOS: begin
                if (r_depth == '0) begin
                  r_uf    <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_state <= S_TOS_A;
                end
              end
              default: begin
                if (r_depth < LP_TWO) begin
                  r_uf    <= 1'b1;
                  r_state <= S_DONE;
                end else begin
                  r_state <= S_POP_A;
                end
              end
            endcase
          end
        end
        S_POP_A: r_state <= S_CAP_A;
        S_TOS_A: r_state <= S_CAP_A;
        S_CAP_A: begin
          r_a <= stk_dout;
          case (r_op)
            OP_POP, OP_TOS: begin
              r_result <= stk_dout;
              r_rv     <= 1'b1;
              r_state  <= S_DONE;
            end
            OP_NOT: begin
              r_din   <= w_alu_res;
`ifdef STACK_SEQ_FLAGS_EN
              r_carry <= w_alu_carry;
`endif
              r_state <= S_PUSH_R;
            end
            default: r_state <= S_POP_B;
          endcase
        end
        S_POP_B: r_state <= S_CAP_B;
        S_CAP_B: begin
          r_din   <= w_alu_res;
`ifdef STACK_SEQ_FLAGS_EN
          r_carry <= w_alu_carry;
`endif
          r_state <= S_PUSH_R;
        end
        S_PUSH_R: begin
          if (r_op != OP_PUSH) begin
            r_result <= r_din;
            r_rv     <= 1'b1;
`ifdef STACK_SEQ_FLAGS_EN
            r_flag_z <= (r_din == '0);
            r_flag_c <= r_carry;
`endif
          end
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign stk_push      = (r_state == S_PUSH_R);
  assign stk_pop       = (r_state == S_POP_A) || (r_state == S_POP_B);
  assign stk_tos       = (r_state == S_TOS_A);
  assign op_done       = (r_state == S_DONE);
  assign stk_din       = r_din;
  assign result        = r_result;
  assign result_valid  = r_rv;
  assign err_underflow = r_uf;
  assign err_overflow  = r_of;
  assign depth         = r_depth;
`ifdef STACK_SEQ_FLAGS_EN
  assign flag_z        = r_flag_z;
  assign flag_c        = r_flag_c;
`endif

endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: directed scoreboard bench for stack_op_sequencer.
// Optional feature macro: STACK_SEQ_FLAGS_EN (flag outputs checked when set).
module tb_stack_op_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_imm;
  logic [7:0] stk_din;
  logic       stk_push;
  logic       stk_pop;
  logic       stk_tos;
  logic [7:0] stk_dout;
  logic [7:0] result;
  logic       result_valid;
  logic       op_done;
  logic       err_underflow;
  logic       err_overflow;
  logic [5:0] depth;
`ifdef STACK_SEQ_FLAGS_EN
  logic       flag_z;
  logic       flag_c;
`endif

  stack_op_sequencer #(
    .DATA_W (8),
    .DEPTH  (32),
    .DEPTH_W(6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_imm      (cmd_imm),
    .stk_din      (stk_din),
    .stk_push     (stk_push),
    .stk_pop      (stk_pop),
    .stk_tos      (stk_tos),
    .stk_dout     (stk_dout),
    .result       (result),
    .result_valid (result_valid),
    .op_done      (op_done),
    .err_underflow(err_underflow),
    .err_overflow (err_overflow),
    .depth        (depth)
`ifdef STACK_SEQ_FLAGS_EN
    ,
    .flag_z       (flag_z),
    .flag_c       (flag_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural 32x8 stack with registered read port
  logic [7:0] mem [32];
  int sp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp       <= 0;
      stk_dout <= '0;
    end else if (stk_push) begin
      if (sp < 32) mem[sp] <= stk_din;
      sp <= sp + 1;
    end else if (stk_pop) begin
      if (sp > 0) stk_dout <= mem[sp-1];
      sp <= sp - 1;
    end else if (stk_tos) begin
      if (sp > 0) stk_dout <= mem[sp-1];
    end
  end

  typedef struct {
    logic [7:0] res;
    bit         rv;
    bit         uf;
    bit         of;
    int         dep;
    int         lat;
    int         np;
    int         npo;
    int         nt;
    logic [7:0] din;
    bit         fz;
    bit         fc;
    int         t_acc;
  } exp_t;

  exp_t sb[$];

  // Monitor: accumulate strobes per command, compare on each op_done
  int         m_np, m_npo, m_nt;
  bit         m_multi;
  logic [7:0] m_din;
  always @(negedge clk) begin
    if (!rst) begin
      m_np = 0; m_npo = 0; m_nt = 0; m_multi = 0; m_din = '0;
    end else begin
      if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1) m_multi = 1;
      if (stk_push) begin m_np++; m_din = stk_din; end
      if (stk_pop) m_npo++;
      if (stk_tos) m_nt++;
      if (op_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_op_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("latency", cyc - e.t_acc, e.lat);
          chk("result_valid", result_valid, e.rv);
          if (e.rv) chk("result", result, e.res);
          chk("err_underflow", err_underflow, e.uf);
          chk("err_overflow", err_overflow, e.of);
          chk("depth", depth, e.dep);
          chk("push_count", m_np, e.np);
          chk("pop_count", m_npo, e.npo);
          chk("tos_count", m_nt, e.nt);
          if (e.np > 0) chk("stk_din", m_din, e.din);
          chk("strobe_exclusive", m_multi, 0);
`ifdef STACK_SEQ_FLAGS_EN
          chk("flag_z", flag_z, e.fz);
          chk("flag_c", flag_c, e.fc);
`endif
        end
        m_np = 0; m_npo = 0; m_nt = 0; m_multi = 0;
      end else if (result_valid || err_underflow || err_overflow) begin
        chk("status_without_op_done", 1, 0);
      end
    end
  end

  int ed  = 0;
  bit efz = 0;
  bit efc = 0;

  function automatic exp_t mk();
    exp_t e;
    e.res = '0; e.rv = 0; e.uf = 0; e.of = 0; e.dep = ed; e.lat = 1;
    e.np = 0; e.npo = 0; e.nt = 0; e.din = '0; e.fz = efz; e.fc = efc; e.t_acc = 0;
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [7:0] imm, input exp_t e, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 0, 1);
    end else begin
      e.t_acc = cyc;
      sb.push_back(e);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_imm   = imm;
      @(posedge clk);
      #1;
      if (hold) begin
        @(posedge clk);
        @(posedge clk);
        #1;
      end
      cmd_valid = 1'b0;
    end
  endtask

  task automatic t_push(input logic [7:0] v, input bit hold);
    exp_t e = mk();
    e.dep = ed + 1; e.lat = 2; e.np = 1; e.din = v;
    ed++;
    issue(3'd1, v, e, hold);
  endtask

  task automatic t_pop(input logic [7:0] r);
    exp_t e = mk();
    e.rv = 1; e.res = r; e.dep = ed - 1; e.lat = 3; e.npo = 1;
    ed--;
    issue(3'd2, 8'h00, e, 0);
  endtask

  task automatic t_tos(input logic [7:0] r);
    exp_t e = mk();
    e.rv = 1; e.res = r; e.lat = 3; e.nt = 1;
    issue(3'd3, 8'h00, e, 0);
  endtask

  task automatic t_alu(input logic [2:0] op, input logic [7:0] r, input bit c);
    exp_t e;
    efz = (r == 8'h00);
    efc = c;
    e = mk();
    e.rv = 1; e.res = r; e.np = 1; e.din = r;
    if (op == 3'd7) begin
      e.lat = 4; e.npo = 1; e.dep = ed;
    end else begin
      e.lat = 6; e.npo = 2; e.dep = ed - 1;
      ed--;
    end
    issue(op, 8'h00, e, 0);
  endtask

  task automatic t_err(input logic [2:0] op, input logic [7:0] imm, input bit uf, input bit of);
    exp_t e = mk();
    e.uf = uf; e.of = of;
    issue(op, imm, e, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_imm = '0;
    repeat (3) @(negedge clk);
    chk("rst_op_done", op_done, 0);
    chk("rst_strobes", {stk_push, stk_pop, stk_tos}, 0);
    chk("rst_status", {result_valid, err_underflow, err_overflow}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_depth", depth, 0);
    chk("rst_result", result, 0);
    chk("rst_stk_din", stk_din, 0);
`ifdef STACK_SEQ_FLAGS_EN
    chk("rst_flags", {flag_z, flag_c}, 0);
`endif

    // Operand order: a = old top, b = beneath, SUB = b - a
    t_push(8'h05, 0); t_push(8'h03, 0); t_alu(3'd4, 8'h08, 0); t_pop(8'h08);
    t_push(8'h03, 0); t_push(8'h05, 0); t_alu(3'd5, 8'hFE, 1); t_pop(8'hFE);
    t_push(8'h05, 0); t_push(8'h03, 0); t_alu(3'd5, 8'h02, 0); t_pop(8'h02);
    t_push(8'h00, 0); t_push(8'h01, 0); t_alu(3'd5, 8'hFF, 1); t_pop(8'hFF);
    t_push(8'hFF, 0); t_push(8'h01, 0); t_alu(3'd4, 8'h00, 1); t_pop(8'h00);
    t_push(8'hF0, 0); t_push(8'h3C, 0); t_alu(3'd6, 8'h30, 0); t_pop(8'h30);

    // Underflow from empty and with a single entry
    t_err(3'd2, 8'h00, 1, 0);
    t_err(3'd3, 8'h00, 1, 0);
    t_err(3'd7, 8'h00, 1, 0);
    t_push(8'h07, 0);
    t_err(3'd4, 8'h00, 1, 0);
    t_pop(8'h07);

    // Fill to capacity, overflow attempt, peek, then unwind
    for (int i = 0; i < 32; i++) t_push(8'(i), 0);
    t_err(3'd1, 8'h99, 0, 1);
    t_tos(8'h1F);
    for (int i = 31; i >= 0; i--) t_pop(8'(i));

    // cmd_valid held through busy cycles must not re-trigger
    t_push(8'hAA, 1);
    t_alu(3'd7, 8'h55, 0);
    t_pop(8'h55);
    t_err(3'd0, 8'h00, 0, 0);
    drain();

    // Reset in the middle of an ADD (during POP_B)
    t_push(8'h01, 0); t_push(8'h02, 0);
    drain();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_imm = 8'h00;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_reset_in_pop_b", stk_pop, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_strobes", {stk_push, stk_pop, stk_tos}, 0);
    chk("mid_rst_status", {op_done, result_valid, err_underflow, err_overflow}, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_stk_din", stk_din, 0);
    chk("mid_rst_depth", depth, 0);
    ed = 0; efz = 0; efc = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_op_done", op_done, 0);
    t_push(8'h42, 0);
    t_pop(8'h42);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
